// File: rtl/msrv_32_wb_arbiter_if.sv
// ============================================================================
// msrv_32_wb_arbiter_if : writeback request, issue/check and register-file
// write bundle for msrv_32_wb_arbiter.  Revision 1.0
// ============================================================================
`default_nettype none

interface msrv_32_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [2:0]              req_valid_in;
   logic [3*ADDR_W-1:0]     req_addr_in;
   logic [3*DATA_W-1:0]     req_data_in;
   logic [2:0]              req_ready_out;
   logic                    issue_valid_in;
   logic [ADDR_W-1:0]       issue_rd_addr_in;
   logic [ADDR_W-1:0]       chk_rs1_addr_in;
   logic [ADDR_W-1:0]       chk_rs2_addr_in;
   logic [ADDR_W-1:0]       chk_rd_addr_in;
   logic                    hazard_out;
   logic                    wr_en_out;
   logic [ADDR_W-1:0]       rd_addr_out;
   logic [DATA_W-1:0]       rd_out;
   logic [(1<<ADDR_W)-1:0]  busy_out;

   modport slave (
      input  req_valid_in, req_addr_in, req_data_in,
      input  issue_valid_in, issue_rd_addr_in,
      input  chk_rs1_addr_in, chk_rs2_addr_in, chk_rd_addr_in,
      output req_ready_out, hazard_out, wr_en_out, rd_addr_out, rd_out, busy_out
   );

   modport master (
      output req_valid_in, req_addr_in, req_data_in,
      output issue_valid_in, issue_rd_addr_in,
      output chk_rs1_addr_in, chk_rs2_addr_in, chk_rd_addr_in,
      input  req_ready_out, hazard_out, wr_en_out, rd_addr_out, rd_out, busy_out
   );
endinterface

`default_nettype wire

// File: rtl/msrv_32_wb_arbiter.sv
// ============================================================================
// msrv_32_wb_arbiter : three-way register-file writeback arbiter with busy
// scoreboard and decode hazard flag.  Macro MSRV32_WB_ROUND_ROBIN_EN selects
// round-robin arbitration; otherwise fixed priority load > ALU > CSR.
// Revision 1.0
// ============================================================================
`default_nettype none

module msrv_32_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  wire logic            ms_risc32_mp_clk_in,
   input  wire logic            ms_risc32_mp_rst_in,
   msrv_32_wb_arbiter_if.slave  wb
);
   localparam int NREG = 1 << ADDR_W;

   logic [1:0]         sel;
   logic               gnt_any;
   logic [2:0]         grant;
   logic [ADDR_W-1:0]  gnt_addr;
   logic [DATA_W-1:0]  gnt_data;
   logic [NREG-1:0]    busy;
   logic [NREG-1:0]    busy_nxt;
   logic               wr_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic [DATA_W-1:0]  rd_data;

`ifdef MSRV32_WB_ROUND_ROBIN_EN
   logic [1:0] ptr;
   logic [1:0] cand0;
   logic [1:0] cand1;
   logic [1:0] cand2;

   // Search order starts at the pointer and wraps through the other two.
   always_comb begin
      case (ptr)
         2'd1:    {cand0, cand1, cand2} = {2'd1, 2'd2, 2'd0};
         2'd2:    {cand0, cand1, cand2} = {2'd2, 2'd0, 2'd1};
         default: {cand0, cand1, cand2} = {2'd0, 2'd1, 2'd2};
      endcase
      sel     = 2'd0;
      gnt_any = 1'b0;
      if (wb.req_valid_in[cand0]) begin
         sel     = cand0;
         gnt_any = 1'b1;
      end else if (wb.req_valid_in[cand1]) begin
         sel     = cand1;
         gnt_any = 1'b1;
      end else if (wb.req_valid_in[cand2]) begin
         sel     = cand2;
         gnt_any = 1'b1;
      end
   end

   always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
      if (ms_risc32_mp_rst_in) begin
         ptr <= 2'd0;
      end else if (gnt_any) begin
         ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      end
   end
`else
   always_comb begin
      sel     = 2'd0;
      gnt_any = 1'b0;
      if (wb.req_valid_in[1]) begin
         sel     = 2'd1;
         gnt_any = 1'b1;
      end else if (wb.req_valid_in[0]) begin
         sel     = 2'd0;
         gnt_any = 1'b1;
      end else if (wb.req_valid_in[2]) begin
         sel     = 2'd2;
         gnt_any = 1'b1;
      end
   end
`endif

   always_comb begin
      grant = 3'b000;
      if (gnt_any) begin
         grant[sel] = 1'b1;
      end
      case (sel)
         2'd1: begin
            gnt_addr = wb.req_addr_in[ADDR_W +: ADDR_W];
            gnt_data = wb.req_data_in[DATA_W +: DATA_W];
         end
         2'd2: begin
            gnt_addr = wb.req_addr_in[2*ADDR_W +: ADDR_W];
            gnt_data = wb.req_data_in[2*DATA_W +: DATA_W];
         end
         default: begin
            gnt_addr = wb.req_addr_in[0 +: ADDR_W];
            gnt_data = wb.req_data_in[0 +: DATA_W];
         end
      endcase
   end

   // Grants are suppressed while reset is held so no requester sees a transfer.
   assign wb.req_ready_out = ms_risc32_mp_rst_in ? 3'b000 : grant;

   // Clear first, then set: a newer issue to the same register stays in flight.
   always_comb begin
      busy_nxt = busy;
      if (gnt_any) begin
         busy_nxt[gnt_addr] = 1'b0;
      end
      if (wb.issue_valid_in && (wb.issue_rd_addr_in != '0)) begin
         busy_nxt[wb.issue_rd_addr_in] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
      if (ms_risc32_mp_rst_in) begin
         busy    <= '0;
         wr_en   <= 1'b0;
         rd_addr <= '0;
         rd_data <= '0;
      end else begin
         busy  <= busy_nxt;
         wr_en <= gnt_any && (gnt_addr != '0);
         if (gnt_any) begin
            rd_addr <= gnt_addr;
            rd_data <= gnt_data;
         end
      end
   end

   assign wb.wr_en_out   = wr_en;
   assign wb.rd_addr_out = rd_addr;
   assign wb.rd_out      = rd_data;
   assign wb.busy_out    = busy;
   assign wb.hazard_out  = busy[wb.chk_rs1_addr_in]
                         | busy[wb.chk_rs2_addr_in]
                         | busy[wb.chk_rd_addr_in];

endmodule

`default_nettype wire

// File: tb/tb_msrv_32_wb_arbiter.sv
// ============================================================================
// tb_msrv_32_wb_arbiter : directed bench with a per-cycle behavioural model of
// the writeback arbiter and scoreboard.  Revision 1.0
// ============================================================================
`default_nettype none

module tb_msrv_32_wb_arbiter;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 0;

   msrv_32_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   msrv_32_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .ms_risc32_mp_clk_in (clk),
      .ms_risc32_mp_rst_in (rst),
      .wb                  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: what the register file port and scoreboard must hold.
   logic [31:0] m_busy;
   logic        m_wr_en;
   logic [4:0]  m_rd_addr;
   logic [31:0] m_rd;
   int          m_ptr;

   function automatic int pick(logic [2:0] v, int p);
`ifdef MSRV32_WB_ROUND_ROBIN_EN
      for (int k = 0; k < 3; k++) begin
         int i;
         i = (p + k) % 3;
         if (v[i]) return i;
      end
      return -1;
`else
      if (v[1]) return 1;
      if (v[0]) return 0;
      if (v[2]) return 2;
      return -1;
`endif
   endfunction

   function automatic logic [2:0] exp_ready();
      int g;
      g = pick(bus.req_valid_in, m_ptr);
      if (rst || g < 0) return 3'b000;
      return 3'(1 << g);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy    = '0;
      m_wr_en   = 1'b0;
      m_rd_addr = '0;
      m_rd      = '0;
      m_ptr     = 0;
   endtask

   // Advance one clock: compute the model's next state from the held inputs.
   task automatic tick();
      int          g;
      logic [4:0]  a;
      logic [31:0] n_busy;
      logic        n_wr;
      logic [4:0]  n_addr;
      logic [31:0] n_data;
      int          n_ptr;
      g      = pick(bus.req_valid_in, m_ptr);
      n_busy = m_busy;
      n_wr   = 1'b0;
      n_addr = m_rd_addr;
      n_data = m_rd;
      n_ptr  = m_ptr;
      if (g >= 0) begin
         a         = bus.req_addr_in[g*5 +: 5];
         n_busy[a] = 1'b0;
         n_wr      = (a != 5'd0);
         n_addr    = a;
         n_data    = bus.req_data_in[g*32 +: 32];
         n_ptr     = (g + 1) % 3;
      end
      if (bus.issue_valid_in && bus.issue_rd_addr_in != 5'd0)
         n_busy[bus.issue_rd_addr_in] = 1'b1;
      @(posedge clk);
      if (!rst) begin
         m_busy    = n_busy;
         m_wr_en   = n_wr;
         m_rd_addr = n_addr;
         m_rd      = n_data;
         m_ptr     = n_ptr;
      end
      #1;
   endtask

   task automatic set_req(int i, logic [4:0] addr, logic [31:0] data);
      bus.req_valid_in[i]          = 1'b1;
      bus.req_addr_in[i*5 +: 5]    = addr;
      bus.req_data_in[i*32 +: 32]  = data;
   endtask

   task automatic clear_inputs();
      bus.req_valid_in     = '0;
      bus.req_addr_in      = '0;
      bus.req_data_in      = '0;
      bus.issue_valid_in   = 1'b0;
      bus.issue_rd_addr_in = '0;
      bus.chk_rs1_addr_in  = '0;
      bus.chk_rs2_addr_in  = '0;
      bus.chk_rd_addr_in   = '0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ready",   bus.req_ready_out, exp_ready());
         check("hazard",  bus.hazard_out,
               m_busy[bus.chk_rs1_addr_in] | m_busy[bus.chk_rs2_addr_in] | m_busy[bus.chk_rd_addr_in]);
         check("wr_en",   bus.wr_en_out,   m_wr_en);
         check("rd_addr", bus.rd_addr_out, m_rd_addr);
         check("rd",      bus.rd_out,      m_rd);
         check("busy",    bus.busy_out,    m_busy);
      end
   end

   logic [2:0] exp_seq [6];

   initial begin
      rst = 1'b1;
      clear_inputs();
      model_reset();
      cmp_en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_wr_en", bus.wr_en_out, 1'b0);
      check("reset_busy",  bus.busy_out, 32'h0);
      check("reset_ready", bus.req_ready_out, 3'b000);

      // Reset asserted mid-cycle while a write is in flight.
      bus.issue_valid_in = 1'b1; bus.issue_rd_addr_in = 5'd3;
      tick();
      bus.issue_rd_addr_in = 5'd4;
      set_req(0, 5'd3, 32'h11);
      tick();
      bus.issue_valid_in = 1'b0;
      check("t1_wr_en_before", bus.wr_en_out, 1'b1);
      check("t1_busy_before",  bus.busy_out, 32'h0000_0010);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("t1_wr_en_async", bus.wr_en_out, 1'b0);
      check("t1_busy_async",  bus.busy_out, 32'h0);
      check("t1_ready_async", bus.req_ready_out, 3'b000);
      tick();
      rst = 1'b0;
      clear_inputs();
      tick();
      tick();
      check("t1_idle_wr_en", bus.wr_en_out, 1'b0);

      // Single write.
      bus.issue_valid_in = 1'b1; bus.issue_rd_addr_in = 5'd5;
      tick();
      bus.issue_valid_in = 1'b0;
      check("t2_busy5_set", bus.busy_out[5], 1'b1);
      set_req(0, 5'd5, 32'hDEADBEEF);
      #1;
      check("t2_ready", bus.req_ready_out, 3'b001);
      tick();
      check("t2_wr_en",   bus.wr_en_out, 1'b1);
      check("t2_rd_addr", bus.rd_addr_out, 5'd5);
      check("t2_rd",      bus.rd_out, 32'hDEADBEEF);
      check("t2_busy5",   bus.busy_out[5], 1'b0);
      clear_inputs();
      tick();

      // Contention with all three requesters continuously valid.
      pulse_reset();
`ifdef MSRV32_WB_ROUND_ROBIN_EN
      exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
      exp_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
`endif
      set_req(0, 5'd1, 32'hA0A0_0001);
      set_req(1, 5'd2, 32'hB0B0_0002);
      set_req(2, 5'd3, 32'hC0C0_0003);
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("t3_grant%0d", k), bus.req_ready_out, exp_seq[k]);
         tick();
      end
`ifdef MSRV32_WB_ROUND_ROBIN_EN
      check("t3_last_addr", bus.rd_addr_out, 5'd3);
`else
      check("t3_last_addr", bus.rd_addr_out, 5'd2);
`endif
      clear_inputs();
      tick();

      // Hazard on rs2 until the CSR writeback lands.
      bus.issue_valid_in = 1'b1; bus.issue_rd_addr_in = 5'd7;
      tick();
      bus.issue_valid_in = 1'b0;
      bus.chk_rs2_addr_in = 5'd7;
      #1;
      check("t4_hazard_set", bus.hazard_out, 1'b1);
      set_req(2, 5'd7, 32'h77);
      #1;
      check("t4_ready", bus.req_ready_out, 3'b100);
      tick();
      check("t4_hazard_clr", bus.hazard_out, 1'b0);
      check("t4_rd_addr",    bus.rd_addr_out, 5'd7);
      clear_inputs();
      tick();

      // Simultaneous set and clear of x9.
      bus.issue_valid_in = 1'b1; bus.issue_rd_addr_in = 5'd9;
      tick();
      set_req(0, 5'd9, 32'h99);
      tick();
      check("t5_busy9", bus.busy_out[9], 1'b1);
      check("t5_wr_en", bus.wr_en_out, 1'b1);
      bus.issue_valid_in = 1'b0;
      tick();
      check("t5_busy9_done", bus.busy_out[9], 1'b0);
      clear_inputs();

      // Writes to x0 are granted but never reach the register file.
      bus.issue_valid_in = 1'b1; bus.issue_rd_addr_in = 5'd0;
      tick();
      bus.issue_valid_in = 1'b0;
      check("t6_busy_after_issue", bus.busy_out, 32'h0);
      set_req(0, 5'd0, 32'h1234);
      #1;
      check("t6_ready", bus.req_ready_out, 3'b001);
      tick();
      check("t6_wr_en", bus.wr_en_out, 1'b0);
      check("t6_busy",  bus.busy_out, 32'h0);
      clear_inputs();
      tick();

      // Mixed traffic sweep, checked only by the per-cycle model.
      for (int i = 0; i < 24; i++) begin
         bus.req_valid_in     = 3'(i % 8);
         bus.req_addr_in      = {5'((i*3+2) % 32), 5'((i*3+1) % 32), 5'((i*3) % 32)};
         bus.req_data_in      = {32'(i*3+2), 32'(i*3+1), 32'(i*3)};
         bus.issue_valid_in   = (i % 2) == 1;
         bus.issue_rd_addr_in = 5'((i*5) % 32);
         bus.chk_rs1_addr_in  = 5'((i*7) % 32);
         bus.chk_rs2_addr_in  = 5'(i % 32);
         bus.chk_rd_addr_in   = 5'((i*11) % 32);
         tick();
      end
      clear_inputs();
      tick();
      tick();
      cmp_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/msrv_32_wb_arbiter.md
Name: msrv_32_wb_arbiter

Overview:
- Shares the single integer register-file write port between three writeback requesters: ALU (req 0), load unit (req 1) and CSR unit (req 2).
- Keeps a 32-entry busy scoreboard of destination registers that have issued but not yet written back.
- Drives a hazard flag so the issue stage can stall.
- Sits between the execute/memory units and the register file. Its registered outputs connect directly to the register file's rd_addr_in, rd_in and wr_en_in.

Parameters:
- DATA_W, 32, width of writeback data.
- ADDR_W, 5, width of register address; the scoreboard has 2**ADDR_W entries.

Ports:
- ms_risc32_mp_clk_in  input  1  system clock, rising-edge.
- ms_risc32_mp_rst_in  input  1  asynchronous, active-high reset.
- req_valid_in  input  3  per-requester writeback request.
- req_addr_in  input  3*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W].
- req_data_in  input  3*DATA_W  writeback data, requester i at bits [i*DATA_W +: DATA_W].
- req_ready_out  output  3  grant, one-hot or zero; combinational.
- issue_valid_in  input  1  an instruction with a destination register issues this cycle.
- issue_rd_addr_in  input  ADDR_W  destination of the issuing instruction.
- chk_rs1_addr_in  input  ADDR_W  source 1 of the instruction in decode.
- chk_rs2_addr_in  input  ADDR_W  source 2 of the instruction in decode.
- chk_rd_addr_in  input  ADDR_W  destination of the instruction in decode.
- hazard_out  output  1  decode must stall; combinational from the scoreboard.
- wr_en_out  output  1  register-file write enable; registered.
- rd_addr_out  output  ADDR_W  register-file write address; registered.
- rd_out  output  DATA_W  register-file write data; registered.
- busy_out  output  32  scoreboard bits, for debug and coverage.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - wr_en_out = 0, rd_addr_out = 0, rd_out = 0.
  - busy = 0.
  - Round-robin pointer = 0.
  - req_ready_out is therefore 0 for every requester while no request is valid.
- Arbitration is combinational:
  - At most one req_ready_out bit is high, and only for a requester whose valid bit is high.
  - A transfer happens when req_valid_in[i] && req_ready_out[i].
  - A requester holds valid, addr and data stable until it is granted; the arbiter does not check this.
- Latency: grant in cycle N puts wr_en_out = 1 with the granted address and data in cycle N+1. If no grant in N, then wr_en_out = 0 in N+1 and rd_addr_out / rd_out hold their previous values.
- Throughput: one write per cycle; no bubble between back-to-back grants.
- Address 0:
  - A request to address 0 is granted normally and advances the pointer.
  - The registered cycle that follows has wr_en_out = 0.
  - It does not touch the scoreboard.
- Scoreboard:
  - busy[0] is constant 0.
  - On a clock edge with issue_valid_in && issue_rd_addr_in != 0, busy[issue_rd_addr_in] is set.
  - On a grant edge, busy[granted addr] is cleared.
  - If set and clear hit the same register on the same edge, set wins (the newer instruction is still in flight).
  - The clear lands on the same edge that raises wr_en_out. The register file's write-through bypass therefore covers the cycle in which busy has just dropped.
- Hazard: hazard_out = busy[chk_rs1_addr_in] | busy[chk_rs2_addr_in] | busy[chk_rd_addr_in].
  - Using rd in the check enforces in-order writeback per register (WAW).
  - Issuing while hazard_out is high is the caller's error; the block still sets the bit.
- Reset mid-operation: all in-flight grants and the busy state are discarded. wr_en_out drops immediately, without waiting for a clock edge.

Optional Feature:
- Macro: MSRV32_WB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Priority search starts at the pointer and wraps 0 -> 1 -> 2 -> 0.
  - After a grant to requester i, the pointer becomes (i+1) mod 3.
  - With all three requesters continuously valid, grants rotate strictly 0, 1, 2, 0, ...
- Undefined: fixed priority, load (1) > ALU (0) > CSR (2).
  - No pointer register exists.
  - Starvation of lower-priority requesters is accepted.

Test Plan:
1. Reset then idle: assert reset mid-cycle while req 0 is valid -> wr_en_out, busy_out and req_ready_out are 0 immediately; after release with no requests, wr_en_out stays 0.
2. Single write: issue rd=5, then req 0 valid with addr 5, data 0xDEADBEEF -> busy_out[5] = 1 after issue; ready[0] = 1 in the request cycle; next cycle wr_en_out = 1, rd_addr_out = 5, rd_out = 0xDEADBEEF, busy_out[5] = 0.
3. Contention: all three valid for 6 cycles with addrs 1, 2, 3 -> round-robin grants 0, 1, 2, 0, 1, 2; fixed priority grants requester 1 six times.
4. Hazard: busy[7] = 1 with chk_rs2 = 7 -> hazard_out = 1; hazard_out drops in the cycle after req 2 (addr 7) is granted.
5. Simultaneous set and clear: grant to addr 9 on the same edge as issue rd=9 -> busy_out[9] remains 1.
6. x0 handling: issue rd=0, then request addr 0 with data 0x1234 -> busy_out stays 0, ready is asserted, next-cycle wr_en_out = 0.
